// File: rtl/semaforo_timer.sv
// -----------------------------------------------------------------------------
// semaforo_timer
//
// Phase timer for the traffic-light controller. Watches the lights driven by
// the light FSM, counts the cycles spent in the current phase and raises
// `timeout` on the last cycle of that phase's configured length. The answer is
// combinational, so the FSM sees it at the very next edge.
//
// Parameters:
//   WIDTH       counter width in bits
//   RED_CYCLES  red phase length in cycles    (1 .. 2^WIDTH-1)
//   YLW_CYCLES  yellow phase length in cycles (1 .. 2^WIDTH-1)
//   GRN_CYCLES  minimum green length          (1 .. 2^WIDTH-1)
//
// Ports:
//   Clock    in   sole clock, rising edge
//   Reset    in   asynchronous, active-high reset
//   red      in   red light from the FSM
//   ylw      in   yellow light from the FSM
//   grn      in   green light from the FSM
//   err      out  sticky illegal-light flag (only with SEMAFORO_TIMER_ERR_EN)
//   timeout  out  current phase has reached its configured length
//
// Optional feature macro: SEMAFORO_TIMER_ERR_EN
//   When defined, more than one light lit at once is illegal: it sets the
//   sticky `err` flag, forces `timeout` low and clears the counter.
//   When undefined, the red > ylw > grn priority alone resolves such cases.
// -----------------------------------------------------------------------------
module semaforo_timer #(
    parameter int WIDTH      = 8,
    parameter int RED_CYCLES = 10,
    parameter int YLW_CYCLES = 1,
    parameter int GRN_CYCLES = 6
) (
    input  logic Clock,
    input  logic Reset,
    input  logic red,
    input  logic ylw,
    input  logic grn,
`ifdef SEMAFORO_TIMER_ERR_EN
    output logic err,
`endif
    output logic timeout
);

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_GRN  = 2'd1,
        PH_YLW  = 2'd2,
        PH_RED  = 2'd3
    } phase_t;

    // Last count value of each phase (LIMIT-1).
    localparam logic [WIDTH-1:0] RED_LAST = WIDTH'(RED_CYCLES - 1);
    localparam logic [WIDTH-1:0] YLW_LAST = WIDTH'(YLW_CYCLES - 1);
    localparam logic [WIDTH-1:0] GRN_LAST = WIDTH'(GRN_CYCLES - 1);

    phase_t           cur;
    phase_t           ph;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] ce;
    logic             illegal;

    // Current phase from the lights, red has priority over yellow over green.
    always_comb begin
        cur = PH_NONE;
        if (red) begin
            cur = PH_RED;
        end else if (ylw) begin
            cur = PH_YLW;
        end else if (grn) begin
            cur = PH_GRN;
        end
    end

    always_comb begin
        case (cur)
            PH_RED:  last = RED_LAST;
            PH_YLW:  last = YLW_LAST;
            PH_GRN:  last = GRN_LAST;
            default: last = '0;
        endcase
    end

`ifdef SEMAFORO_TIMER_ERR_EN
    assign illegal = (red & ylw) | (red & grn) | (ylw & grn);
`else
    assign illegal = 1'b0;
`endif

    // A phase seen for the first time counts 0 in that cycle, whatever is
    // left in the counter from the previous phase.
    assign ce = (cur == ph) ? cnt : '0;

    // The register holds the count of the coming cycle: one more than this
    // cycle's effective count, pinned at the phase's last value so a phase
    // held past its limit keeps timeout high instead of wrapping.
    always_comb begin
        cnt_next = '0;
        if ((cur != PH_NONE) && !illegal) begin
            if (ce >= last) begin
                cnt_next = last;
            end else begin
                cnt_next = ce + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ph  <= PH_NONE;
            cnt <= '0;
        end else begin
            ph  <= cur;
            cnt <= cnt_next;
        end
    end

`ifdef SEMAFORO_TIMER_ERR_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err <= 1'b0;
        end else if (illegal) begin
            err <= 1'b1;
        end
    end
`endif

    // Reset gates the output directly: with a one-cycle phase the compare is
    // already true while the registers are held clear.
    assign timeout = (cur != PH_NONE) && (ce == last) && !Reset && !illegal;

endmodule

// File: tb/tb_semaforo_timer.sv
module tb_semaforo_timer;

`ifdef SEMAFORO_TIMER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Main instance, default parameters.
    logic rst = 1'b1;
    logic red = 1'b0, ylw = 1'b0, grn = 1'b0;
    logic to0;
    logic err0;

    // RED_CYCLES=1, YLW_CYCLES=1 instance.
    logic rst_a = 1'b1;
    logic r1 = 1'b0, y1 = 1'b0, g1 = 1'b0;
    logic to1;

    // Closed-loop instance, RED_CYCLES=4, lights from a small light FSM.
    logic rst_b = 1'b1;
    logic car = 1'b1;
    logic r4, y4, g4;
    logic to4;

`ifdef SEMAFORO_TIMER_ERR_EN
    logic err1, err4;
    semaforo_timer dut (.Clock(Clock), .Reset(rst), .red(red), .ylw(ylw), .grn(grn),
                        .err(err0), .timeout(to0));
    semaforo_timer #(.RED_CYCLES(1), .YLW_CYCLES(1)) dut1 (
        .Clock(Clock), .Reset(rst_a), .red(r1), .ylw(y1), .grn(g1), .err(err1), .timeout(to1));
    semaforo_timer #(.RED_CYCLES(4)) dut4 (
        .Clock(Clock), .Reset(rst_b), .red(r4), .ylw(y4), .grn(g4), .err(err4), .timeout(to4));
`else
    assign err0 = 1'b0;
    semaforo_timer dut (.Clock(Clock), .Reset(rst), .red(red), .ylw(ylw), .grn(grn),
                        .timeout(to0));
    semaforo_timer #(.RED_CYCLES(1), .YLW_CYCLES(1)) dut1 (
        .Clock(Clock), .Reset(rst_a), .red(r1), .ylw(y1), .grn(g1), .timeout(to1));
    semaforo_timer #(.RED_CYCLES(4)) dut4 (
        .Clock(Clock), .Reset(rst_b), .red(r4), .ylw(y4), .grn(g4), .timeout(to4));
`endif

    // Light FSM: green waits for a car and the minimum green, yellow is one
    // cycle, red ends on timeout.
    typedef enum logic [1:0] {F_GRN, F_YLW, F_RED} fsm_t;
    fsm_t fst;
    always_ff @(posedge Clock or posedge rst_b) begin
        if (rst_b) begin
            fst <= F_GRN;
        end else begin
            case (fst)
                F_GRN:   if (car && to4) fst <= F_YLW;
                F_YLW:   fst <= F_RED;
                F_RED:   if (to4) fst <= F_GRN;
                default: fst <= F_GRN;
            endcase
        end
    end
    assign r4 = (fst == F_RED);
    assign y4 = (fst == F_YLW);
    assign g4 = (fst == F_GRN);

    typedef struct {
        string name;
        logic  rs, r, y, g;
        logic  exp_to;
        int    exp_err;   // -1: not compared
        int    exp_cnt;   // -1: not compared
        int    exp_ph;    // -1: not compared
        int    exp_lt;    // -1: not compared, else {red,ylw,grn}
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rs, input logic r, input logic y,
                                input logic g, input logic eto, input int eerr,
                                input int ecnt, input int eph);
        vec_t v;
        v.name    = nm;
        v.rs      = rs;
        v.r       = r;
        v.y       = y;
        v.g       = g;
        v.exp_to  = eto;
        v.exp_err = ERR_EN ? eerr : -1;
        v.exp_cnt = ecnt;
        v.exp_ph  = eph;
        v.exp_lt  = -1;
        return v;
    endfunction

    task automatic add(input string nm, input logic rs, input logic r, input logic y,
                       input logic g, input logic eto, input int eerr, input int ecnt,
                       input int eph, input int n);
        for (int i = 0; i < n; i++)
            tbl.push_back(mk($sformatf("%s[%0d]", nm, i), rs, r, y, g, eto, eerr, ecnt, eph));
    endtask

    task automatic pop_check(input logic a_to, input logic a_err, input logic [31:0] a_cnt,
                             input logic [31:0] a_ph, input logic [31:0] a_lt);
        vec_t v;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: empty queue, got 0 entries, required 1");
            return;
        end
        v = sb.pop_front();
        cmp({v.name, ".timeout"}, 32'(a_to), 32'(v.exp_to));
        if (v.exp_err >= 0) cmp({v.name, ".err"}, 32'(a_err), v.exp_err);
        if (v.exp_cnt >= 0) cmp({v.name, ".cnt"}, a_cnt, v.exp_cnt);
        if (v.exp_ph >= 0)  cmp({v.name, ".ph"}, a_ph, v.exp_ph);
        if (v.exp_lt >= 0)  cmp({v.name, ".lights"}, a_lt, v.exp_lt);
    endtask

    task automatic step_main(input vec_t v);
        @(posedge Clock);
        #1;
        rst = v.rs; red = v.r; ylw = v.y; grn = v.g;
        sb.push_back(v);
        @(negedge Clock);
        pop_check(to0, err0, 32'(dut.cnt), 32'(dut.ph), 0);
    endtask

    task automatic step_one(input vec_t v);
        @(posedge Clock);
        #1;
        rst_a = v.rs; r1 = v.r; y1 = v.y; g1 = v.g;
        sb.push_back(v);
        @(negedge Clock);
        pop_check(to1, 1'b0, 32'(dut1.cnt), 0, 0);
    endtask

    task automatic step_loop(input vec_t v);
        @(posedge Clock);
        #1;
        rst_b = 1'b0;
        sb.push_back(v);
        @(negedge Clock);
        pop_check(to4, 1'b0, 0, 0, 32'({r4, y4, g4}));
    endtask

    initial begin
        vec_t v;
        int e;
        e = ERR_EN ? 1 : 0;

        // ---- vector table for the default-parameter instance ----
        add("rst_hold",   1, 1, 0, 0, 0, 0, 0, 0, 3);
        add("red_cnt",    0, 1, 0, 0, 0, 0, -1, -1, 9);
        add("red_to",     0, 1, 0, 0, 1, 0, -1, -1, 3);
        add("grn_cnt",    0, 0, 0, 1, 0, 0, -1, -1, 5);
        add("grn_sat",    0, 0, 0, 1, 1, 0, -1, -1, 14);
        add("grn_c20",    0, 0, 0, 1, 1, 0, 5, 1, 1);
        add("ylw",        0, 0, 1, 0, 1, 0, -1, -1, 2);
        add("none",       0, 0, 0, 0, 0, 0, -1, -1, 1);
        add("none2",      0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("red_pre",    0, 1, 0, 0, 0, 0, -1, -1, 3);
        add("red_grn",    0, 1, 0, 1, 0, 0, -1, -1, 1);
        add("red_post",   0, 1, 0, 0, 0, e, ERR_EN ? 0 : 4, -1, 1);
        add("red_run",    0, 1, 0, 0, 0, e, -1, -1, ERR_EN ? 8 : 4);
        add("red_end",    0, 1, 0, 0, 1, e, -1, -1, 1);
        add("ylw_grn",    0, 0, 1, 1, ERR_EN ? 1'b0 : 1'b1, e, -1, -1, 1);
        add("rst_clr",    1, 0, 0, 0, 0, 0, 0, 0, 1);

        foreach (tbl[i]) step_main(tbl[i]);

        // ---- asynchronous reset in the middle of a red phase ----
        for (int i = 0; i < 7; i++)
            step_main(mk($sformatf("mid_red[%0d]", i), 0, 1, 0, 0, 0, 0, -1, -1));
        @(posedge Clock);
        #3;
        cmp("mid_cnt_before", 32'(dut.cnt), 7);
        rst = 1'b1;
        #1;
        cmp("mid_timeout", 32'(to0), 0);
        cmp("mid_cnt", 32'(dut.cnt), 0);
        cmp("mid_ph", 32'(dut.ph), 0);
        for (int i = 0; i < 9; i++)
            step_main(mk($sformatf("mid_rel[%0d]", i), 0, 1, 0, 0, 0, 0, -1, -1));
        step_main(mk("mid_rel_to", 0, 1, 0, 0, 1, 0, -1, -1));

        // ---- one-cycle phases: red, yellow, red ... ----
        v = mk("one_rst", 1, 1, 0, 0, 0, 0, 0, -1);
        v.exp_err = -1;
        step_one(v);
        for (int i = 0; i < 5; i++) begin
            v = mk($sformatf("one_alt[%0d]", i), 0, (i % 2) == 0, (i % 2) == 1, 0, 1, 0, 0, -1);
            v.exp_err = -1;
            step_one(v);
        end
        v = mk("one_none", 0, 0, 0, 0, 0, 0, 0, -1);
        v.exp_err = -1;
        step_one(v);

        // ---- closed loop with the light FSM, RED_CYCLES=4 ----
        for (int i = 0; i < 12; i++) begin
            v = mk($sformatf("loop[%0d]", i), 0, 0, 0, 0,
                   (i == 5) || (i == 6) || (i == 10), 0, -1, -1);
            v.exp_err = -1;
            if (i <= 5 || i == 11) v.exp_lt = 3'b001;
            else if (i == 6)       v.exp_lt = 3'b010;
            else                   v.exp_lt = 3'b100;
            step_loop(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
